// File: rtl/assoc_data_cache.sv
// 2-way set-associative, write-back, write-allocate data cache with per-set LRU.
// The CPU side stalls on BUSYWAIT; the memory side moves whole 32-bit blocks.
module assoc_data_cache #(
    parameter int ADDR_W  = 8,
    parameter int INDEX_W = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [7:0]        WRITEDATA,
    output logic [7:0]        READDATA,
    output logic              BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-3:0] MEM_ADDRESS,
    output logic [31:0]       MEM_WRITEDATA,
    input  logic [31:0]       MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);
    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_e;

    state_e             state_q;
    logic [SETS-1:0]    valid_q [2];
    logic [SETS-1:0]    dirty_q [2];
    logic [SETS-1:0]    lru_q;
    logic [TAG_W-1:0]   tag_q   [2][SETS];
    logic [31:0]        data_q  [2][SETS];

    logic               victim_q;
    logic [TAG_W-1:0]   miss_tag_q;
    logic [INDEX_W-1:0] miss_idx_q;
    logic [31:0]        fill_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic [ADDR_W-3:0]  mem_addr_q;
    logic [31:0]        mem_wdata_q;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [1:0]         req_off;
    logic [1:0]         hit_way;
    logic               hit;
    logic               hit_sel;
    logic               victim;
    logic               request;
    logic               idle;
    logic               byte_we;
    logic [31:0]        hit_block;

    assign req_tag = ADDRESS[ADDR_W-1 -: TAG_W];
    assign req_idx = ADDRESS[2 +: INDEX_W];
    assign req_off = ADDRESS[1:0];

    assign hit_way[0] = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit_way[1] = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign hit        = |hit_way;
    assign hit_sel    = hit_way[1];
    assign request    = READ | WRITE;
    assign idle       = (state_q == IDLE);
    assign hit_block  = data_q[hit_sel][req_idx];
    // READ has priority, so a simultaneous WRITE never touches the line.
    assign byte_we    = idle && WRITE && !READ && hit;

    // NOTE: victim gets its default first so every path assigns it and no latch is inferred.
    always_comb begin
        victim = lru_q[req_idx];
        if (!valid_q[0][req_idx]) begin
            victim = 1'b0;
        end else if (!valid_q[1][req_idx]) begin
            victim = 1'b1;
        end
    end

    assign READDATA      = (!RESET && idle && READ && hit) ? hit_block[{req_off, 3'b000} +: 8] : 8'h00;
    assign BUSYWAIT      = !RESET && (!idle || (request && !hit));
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;

    // NOTE: tag/data storage has no reset; valid bits alone decide whether its contents matter.
    always_ff @(posedge CLK) begin
        if (state_q == UPDATE) begin
            data_q[victim_q][miss_idx_q] <= fill_q;
            tag_q[victim_q][miss_idx_q]  <= miss_tag_q;
        end else if (byte_we) begin
            data_q[hit_sel][req_idx][{req_off, 3'b000} +: 8] <= WRITEDATA;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            valid_q[0]  <= '0;
            valid_q[1]  <= '0;
            dirty_q[0]  <= '0;
            dirty_q[1]  <= '0;
            lru_q       <= '0;
            victim_q    <= 1'b0;
            miss_tag_q  <= '0;
            miss_idx_q  <= '0;
            fill_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (request && hit) begin
                        lru_q[req_idx] <= ~hit_sel;
                        if (byte_we) dirty_q[hit_sel][req_idx] <= 1'b1;
                    end else if (request) begin
                        victim_q   <= victim;
                        miss_tag_q <= req_tag;
                        miss_idx_q <= req_idx;
                        if (dirty_q[victim][req_idx]) begin
                            state_q     <= WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[victim][req_idx], req_idx};
                            mem_wdata_q <= data_q[victim][req_idx];
                        end else begin
                            state_q    <= ALLOCATE;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= {req_tag, req_idx};
                        end
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state_q     <= ALLOCATE;
                        mem_write_q <= 1'b0;
                        mem_wdata_q <= '0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= {miss_tag_q, miss_idx_q};
                    end
                end
                ALLOCATE: begin
                    if (!MEM_BUSYWAIT) begin
                        state_q    <= UPDATE;
                        mem_read_q <= 1'b0;
                        mem_addr_q <= '0;
                        fill_q     <= MEM_READDATA;
                    end
                end
                UPDATE: begin
                    state_q                       <= IDLE;
                    valid_q[victim_q][miss_idx_q] <= 1'b1;
                    dirty_q[victim_q][miss_idx_q] <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_assoc_data_cache.sv
// Directed bench for assoc_data_cache: default build (a) and an 8-set, 10-bit build (b),
// each backed by a fixed-latency block memory whose byte at address x reads as x[7:0].
module tb_assoc_data_cache;
    localparam int LAT = 2;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    logic        rd_a = 0, wr_a = 0, busy_a, mrd_a, mwr_a, mbusy_a;
    logic [7:0]  addr_a = 0, wdata_a = 0, rdata_a;
    logic [5:0]  maddr_a;
    logic [31:0] mwdata_a, mrdata_a;
    logic        rd_b = 0, wr_b = 0, busy_b, mrd_b, mwr_b, mbusy_b;
    logic [9:0]  addr_b = 0;
    logic [7:0]  wdata_b = 0, rdata_b;
    logic [7:0]  maddr_b;
    logic [31:0] mwdata_b, mrdata_b;

    assoc_data_cache #(.ADDR_W(8), .INDEX_W(2)) dut_a (
        .CLK(CLK), .RESET(RESET), .READ(rd_a), .WRITE(wr_a), .ADDRESS(addr_a),
        .WRITEDATA(wdata_a), .READDATA(rdata_a), .BUSYWAIT(busy_a),
        .MEM_READ(mrd_a), .MEM_WRITE(mwr_a), .MEM_ADDRESS(maddr_a),
        .MEM_WRITEDATA(mwdata_a), .MEM_READDATA(mrdata_a), .MEM_BUSYWAIT(mbusy_a)
    );

    assoc_data_cache #(.ADDR_W(10), .INDEX_W(3)) dut_b (
        .CLK(CLK), .RESET(RESET), .READ(rd_b), .WRITE(wr_b), .ADDRESS(addr_b),
        .WRITEDATA(wdata_b), .READDATA(rdata_b), .BUSYWAIT(busy_b),
        .MEM_READ(mrd_b), .MEM_WRITE(mwr_b), .MEM_ADDRESS(maddr_b),
        .MEM_WRITEDATA(mwdata_b), .MEM_READDATA(mrdata_b), .MEM_BUSYWAIT(mbusy_b)
    );

    // Memory models: busy for LAT cycles after a request appears, then one ready cycle.
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [256];
    int cnt_a = 0, cnt_b = 0;
    int n_rd_a = 0, n_wr_a = 0, n_rd_b = 0;
    logic [5:0]  last_rd_a = 0, last_wr_a = 0;
    logic [7:0]  last_rd_b = 0;
    logic [31:0] last_wd_a = 0;
    logic        both_a = 0;

    assign mbusy_a  = (mrd_a || mwr_a) && (cnt_a < LAT);
    assign mbusy_b  = (mrd_b || mwr_b) && (cnt_b < LAT);
    assign mrdata_a = mem_a[maddr_a];
    assign mrdata_b = mem_b[maddr_b];

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_a <= 0;
            cnt_b <= 0;
        end else begin
            cnt_a <= (!(mrd_a || mwr_a) || cnt_a == LAT) ? 0 : cnt_a + 1;
            cnt_b <= (!(mrd_b || mwr_b) || cnt_b == LAT) ? 0 : cnt_b + 1;
        end
    end

    always @(posedge CLK) begin
        if (mrd_a && mwr_a) both_a <= 1'b1;
        if (mrd_a && !mbusy_a) begin
            n_rd_a    <= n_rd_a + 1;
            last_rd_a <= maddr_a;
        end
        if (mwr_a && !mbusy_a) begin
            n_wr_a         <= n_wr_a + 1;
            last_wr_a      <= maddr_a;
            last_wd_a      <= mwdata_a;
            mem_a[maddr_a] <= mwdata_a;
        end
        if (mrd_b && !mbusy_b) begin
            n_rd_b    <= n_rd_b + 1;
            last_rd_b <= maddr_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at a falling edge, holds the request until BUSYWAIT is low, drops it a cycle later.
    task automatic access(input bit b, input bit rd, input bit wr, input logic [9:0] addr,
                          input logic [7:0] wd, output int stall, output logic [7:0] rdata);
        if (b) begin
            rd_b = rd; wr_b = wr; addr_b = addr; wdata_b = wd;
        end else begin
            rd_a = rd; wr_a = wr; addr_a = addr[7:0]; wdata_a = wd;
        end
        stall = 0;
        #1;
        while ((b ? busy_b : busy_a) && stall < 100) begin
            stall++;
            @(negedge CLK);
            #1;
        end
        check("no_timeout", 32'(stall < 100), 32'd1);
        rdata = b ? rdata_b : rdata_a;
        @(negedge CLK);
        if (b) begin
            rd_b = 0; wr_b = 0;
        end else begin
            rd_a = 0; wr_a = 0;
        end
    endtask

    initial begin
        int st;
        logic [7:0] rd;
        for (int i = 0; i < 64; i++)  mem_a[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        for (int i = 0; i < 256; i++) mem_b[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        mem_a[0] = 32'h44332211;

        rd_a = 1;
        #1 RESET = 1;
        #2;
        check("rst_busywait", busy_a, 0);
        check("rst_mem_read", mrd_a, 0);
        check("rst_mem_write", mwr_a, 0);
        check("rst_mem_addr", maddr_a, 0);
        check("rst_mem_wdata", mwdata_a, 0);
        check("rst_readdata", rdata_a, 0);
        @(negedge CLK);
        RESET = 0;
        rd_a  = 0;

        access(0, 1, 0, 10'h000, 8'h00, st, rd);
        check("miss0_stall", st, LAT + 3);
        check("miss0_data", rd, 8'h11);
        check("miss0_mem_addr", last_rd_a, 6'h00);
        access(0, 1, 0, 10'h003, 8'h00, st, rd);
        check("hit3_stall", st, 0);
        check("hit3_data", rd, 8'h44);
        check("hit3_no_fetch", n_rd_a, 1);

        access(0, 0, 1, 10'h005, 8'hAB, st, rd);
        check("wmiss_stall", st, LAT + 3);
        check("wmiss_mem_addr", last_rd_a, 6'h01);
        access(0, 1, 0, 10'h005, 8'h00, st, rd);
        check("wmiss_readback", rd, 8'hAB);
        check("wmiss_stall_rb", st, 0);
        check("wmiss_reads", n_rd_a, 2);

        // Set 0: way0 = block 0x00, way1 = block 0x04, then 0x20 must displace block 0x04.
        access(0, 1, 0, 10'h010, 8'h00, st, rd);
        check("fill10_data", rd, 8'h10);
        access(0, 1, 0, 10'h000, 8'h00, st, rd);
        check("touch00_stall", st, 0);
        access(0, 1, 0, 10'h020, 8'h00, st, rd);
        check("evict_clean_data", rd, 8'h20);
        check("evict_clean_addr", last_rd_a, 6'h08);
        check("evict_clean_no_wb", n_wr_a, 0);
        access(0, 1, 0, 10'h000, 8'h00, st, rd);
        check("keep00_stall", st, 0);
        check("keep00_data", rd, 8'h11);
        access(0, 1, 0, 10'h010, 8'h00, st, rd);
        check("refetch10_miss", 32'(st > 0), 1);

        // Dirty eviction of block 0x00 holding 0x7E in byte 0.
        access(0, 0, 1, 10'h000, 8'h7E, st, rd);
        check("whit_stall", st, 0);
        access(0, 1, 0, 10'h010, 8'h00, st, rd);
        check("touch10_stall", st, 0);
        access(0, 1, 0, 10'h020, 8'h00, st, rd);
        check("dirty_wb_count", n_wr_a, 1);
        check("dirty_wb_addr", last_wr_a, 6'h00);
        check("dirty_wb_data", last_wd_a, 32'h4433227E);
        check("dirty_fetch_addr", last_rd_a, 6'h08);
        check("dirty_read_data", rd, 8'h20);
        access(0, 1, 0, 10'h000, 8'h00, st, rd);
        check("refetch00_stall", st, LAT + 3);
        check("refetch00_data", rd, 8'h7E);
        check("refetch00_no_wb", n_wr_a, 1);

        access(0, 1, 1, 10'h000, 8'h55, st, rd);
        check("rdwr_is_read", rd, 8'h7E);
        access(0, 1, 0, 10'h000, 8'h00, st, rd);
        check("rdwr_no_store", rd, 8'h7E);

        // Reset in the middle of a fetch abandons it.
        rd_a = 1; addr_a = 8'h2C;
        @(posedge CLK);
        #1;
        check("alloc_started", mrd_a, 1);
        #1 RESET = 1;
        #1;
        check("rst_alloc_mem_read", mrd_a, 0);
        check("rst_alloc_busywait", busy_a, 0);
        @(negedge CLK);
        RESET = 0;
        rd_a  = 0;
        access(0, 1, 0, 10'h02C, 8'h00, st, rd);
        check("post_rst_miss", st, LAT + 3);
        check("post_rst_data", rd, 8'h2C);
        check("no_rd_wr_overlap", both_a, 0);

        // Wider build: 0x000 and 0x010 sit in different sets, 0x020 shares set 0 with 0x000.
        access(1, 1, 0, 10'h000, 8'h00, st, rd);
        check("b_fill000", st, LAT + 3);
        access(1, 1, 0, 10'h010, 8'h00, st, rd);
        check("b_fill010", st, LAT + 3);
        check("b_fill010_addr", last_rd_b, 8'h04);
        access(1, 1, 0, 10'h020, 8'h00, st, rd);
        check("b_fill020", st, LAT + 3);
        access(1, 1, 0, 10'h000, 8'h00, st, rd);
        check("b_hit000_stall", st, 0);
        check("b_hit000_data", rd, 8'h00);
        access(1, 1, 0, 10'h010, 8'h00, st, rd);
        check("b_hit010_data", rd, 8'h10);
        check("b_hit010_stall", st, 0);
        access(1, 1, 0, 10'h020, 8'h00, st, rd);
        check("b_hit020_stall", st, 0);
        access(1, 1, 0, 10'h3FF, 8'h00, st, rd);
        check("b_top_addr", last_rd_b, 8'hFF);
        check("b_top_data", rd, 8'hFF);
        check("b_reads", n_rd_b, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
